// File: rtl/hex_decode_scan_if.sv
// Bus between the scan requester and hex_decode_scan: the six segment inputs,
// the start request, and the decoded results and status.
interface hex_decode_scan_if;
  logic        Start;
  logic [6:0]  HEX0;
  logic [6:0]  HEX1;
  logic [6:0]  HEX2;
  logic [6:0]  HEX3;
  logic [6:0]  HEX4;
  logic [6:0]  HEX5;
  logic [23:0] Value;
  logic [5:0]  Valid;
  logic [5:0]  Blank;
  logic [2:0]  ErrCnt;
  logic        Busy;
  logic        Done;

  modport master (
    output Start, HEX0, HEX1, HEX2, HEX3, HEX4, HEX5,
    input  Value, Valid, Blank, ErrCnt, Busy, Done
  );

  modport slave (
    input  Start, HEX0, HEX1, HEX2, HEX3, HEX4, HEX5,
    output Value, Valid, Blank, ErrCnt, Busy, Done
  );
endinterface

// File: rtl/hex_decode_scan.sv
// Scans six active-low seven-segment patterns one digit per cycle and turns
// each back into a hex nibble, flagging blank and unrecognised glyphs.
module hex_decode_scan (
  input  logic              CLOCK_50,
  input  logic              Reset,
  hex_decode_scan_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_nextState;
  logic [2:0]  r_idx;
  logic [23:0] r_value;
  logic [5:0]  r_valid;
  logic [5:0]  r_blank;
  logic [2:0]  r_errCnt;

  logic [6:0]  w_pattern;
  logic [3:0]  w_nibble;
  logic        w_legal;
  logic        w_isBlank;

  // Only the digit addressed by r_idx is looked at in any given cycle.
  always_comb begin
    w_pattern = 7'h7F;
    case (r_idx)
      3'd0:    w_pattern = bus.HEX0;
      3'd1:    w_pattern = bus.HEX1;
      3'd2:    w_pattern = bus.HEX2;
      3'd3:    w_pattern = bus.HEX3;
      3'd4:    w_pattern = bus.HEX4;
      3'd5:    w_pattern = bus.HEX5;
      default: w_pattern = 7'h7F;
    endcase
  end

  always_comb begin
    w_nibble  = 4'h0;
    w_legal   = 1'b1;
    w_isBlank = 1'b0;
    case (w_pattern)
      7'h40: w_nibble = 4'h0;
      7'h79: w_nibble = 4'h1;
      7'h24: w_nibble = 4'h2;
      7'h30: w_nibble = 4'h3;
      7'h19: w_nibble = 4'h4;
      7'h12: w_nibble = 4'h5;
      7'h02: w_nibble = 4'h6;
      7'h78: w_nibble = 4'h7;
      7'h00: w_nibble = 4'h8;
      7'h10: w_nibble = 4'h9;
      7'h08: w_nibble = 4'hA;
      7'h03: w_nibble = 4'hB;
      7'h46: w_nibble = 4'hC;
      7'h21: w_nibble = 4'hD;
      7'h06: w_nibble = 4'hE;
      7'h0E: w_nibble = 4'hF;
      7'h7F: begin
        w_legal   = 1'b0;
        w_isBlank = 1'b1;
      end
      default: w_legal = 1'b0;
    endcase
  end

  always_ff @(posedge CLOCK_50) begin
    if (Reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Start is only honoured from IDLE; requests during SCAN or DONE are dropped.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE:    if (bus.Start) w_nextState = SCAN;
      SCAN:    if (r_idx == 3'd5) w_nextState = DONE;
      DONE:    w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_50) begin
    if (Reset) begin
      r_idx    <= 3'd0;
      r_value  <= 24'h0;
      r_valid  <= 6'h0;
      r_blank  <= 6'h0;
      r_errCnt <= 3'd0;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.Start) begin
            r_idx    <= 3'd0;
            r_errCnt <= 3'd0;
          end
        end
        SCAN: begin
          r_value[4*r_idx +: 4] <= w_nibble;
          r_valid[r_idx]        <= w_legal;
          r_blank[r_idx]        <= w_isBlank;
          if (!w_legal && !w_isBlank) begin
            r_errCnt <= r_errCnt + 3'd1;
          end
          r_idx <= r_idx + 3'd1;
        end
        default: ;
      endcase
    end
  end

  assign bus.Value  = r_value;
  assign bus.Valid  = r_valid;
  assign bus.Blank  = r_blank;
  assign bus.ErrCnt = r_errCnt;
  assign bus.Busy   = (r_state == SCAN);
  assign bus.Done   = (r_state == DONE);

endmodule

// File: tb/tb_hex_decode_scan.sv
// Randomised and directed bench for hex_decode_scan: expected scan results are
// queued at Start and compared by a monitor whenever Done pulses.
module tb_hex_decode_scan;

  logic clk;
  logic rst;
  int   cyc;
  int   totalCount;
  int   passCount;
  int   doneCount;
  int   busyRun;

  typedef struct {
    logic [23:0] value;
    logic [5:0]  valid;
    logic [5:0]  blank;
    logic [2:0]  errCnt;
    int          startCyc;
  } exp_t;

  exp_t sb[$];
  logic [6:0] glyphs [16];
  logic [6:0] hv [6];

  hex_decode_scan_if bus ();

  hex_decode_scan dut (
    .CLOCK_50 (clk),
    .Reset    (rst),
    .bus      (bus.slave)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    totalCount++;
    if (actual === expected) begin
      passCount++;
    end else begin
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  // Reference: position in the glyph table is the digit; 7F is blank; else error.
  function automatic exp_t refScan(input logic [6:0] h [6]);
    exp_t e;
    e.value  = '0;
    e.valid  = '0;
    e.blank  = '0;
    e.errCnt = '0;
    e.startCyc = 0;
    for (int d = 0; d < 6; d++) begin
      int found;
      found = -1;
      for (int g = 0; g < 16; g++) begin
        if (glyphs[g] == h[d]) found = g;
      end
      if (found >= 0) begin
        e.value = e.value | (24'(found) << (4 * d));
        e.valid[d] = 1'b1;
      end else if (h[d] == 7'h7F) begin
        e.blank[d] = 1'b1;
      end else begin
        e.errCnt = e.errCnt + 3'd1;
      end
    end
    return e;
  endfunction

  task automatic applyStimulus(input logic [6:0] h [6]);
    bus.HEX0 = h[0];
    bus.HEX1 = h[1];
    bus.HEX2 = h[2];
    bus.HEX3 = h[3];
    bus.HEX4 = h[4];
    bus.HEX5 = h[5];
  endtask

  task automatic startScan(input logic [6:0] h [6]);
    exp_t e;
    e = refScan(h);
    bus.Start = 1'b1;
    @(posedge clk);
    #1;
    bus.Start = 1'b0;
    e.startCyc = cyc;
    sb.push_back(e);
  endtask

  task automatic runScan(input logic [6:0] h [6]);
    applyStimulus(h);
    startScan(h);
    repeat (8) @(posedge clk);
    #1;
    checkOutput("scanCompleted", 32'(sb.size()), 32'd0);
    sb.delete();
  endtask

  // Monitor: Done marks a finished scan; compare against the oldest expectation.
  initial begin
    busyRun = 0;
    doneCount = 0;
    forever begin
      @(negedge clk);
      if (bus.Busy) begin
        busyRun++;
      end else if (bus.Done) begin
        doneCount++;
        if (sb.size() == 0) begin
          checkOutput("unexpectedDone", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          checkOutput("Value", 32'(bus.Value), 32'(e.value));
          checkOutput("Valid", 32'(bus.Valid), 32'(e.valid));
          checkOutput("Blank", 32'(bus.Blank), 32'(e.blank));
          checkOutput("ErrCnt", 32'(bus.ErrCnt), 32'(e.errCnt));
          checkOutput("busyCycles", 32'(busyRun), 32'd6);
          checkOutput("doneLatency", 32'(cyc - e.startCyc), 32'd6);
        end
        busyRun = 0;
      end else begin
        busyRun = 0;
      end
    end
  end

  initial begin
    int prevDone;
    totalCount = 0;
    passCount  = 0;
    glyphs = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    hv = '{7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F};
    bus.Start = 1'b0;
    applyStimulus(hv);
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rstValue", 32'(bus.Value), 32'd0);
    checkOutput("rstValid", 32'(bus.Valid), 32'd0);
    checkOutput("rstBlank", 32'(bus.Blank), 32'd0);
    checkOutput("rstErrCnt", 32'(bus.ErrCnt), 32'd0);
    checkOutput("rstBusy", 32'(bus.Busy), 32'd0);
    checkOutput("rstDone", 32'(bus.Done), 32'd0);
    rst = 1'b0;

    // Start on the very first edge after reset releases.
    hv = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12};
    runScan(hv);
    checkOutput("heldValue", 32'(bus.Value), 32'h543210);
    hv = '{7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    runScan(hv);
    hv = '{7'h7F, 7'h55, 7'h00, 7'h7F, 7'h01, 7'h79};
    runScan(hv);
    checkOutput("mixedValue", 32'(bus.Value), 32'h100800);

    // Extra Starts during SCAN and DONE must not queue or restart.
    hv = '{7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40};
    applyStimulus(hv);
    prevDone = doneCount;
    startScan(hv);
    for (int k = 1; k < 10; k++) begin
      bus.Start = (k == 2 || k == 7);
      @(posedge clk);
      #1;
    end
    bus.Start = 1'b0;
    checkOutput("ignoredStartDones", 32'(doneCount - prevDone), 32'd1);
    checkOutput("ignoredStartIdle", 32'(bus.Busy), 32'd0);
    sb.delete();

    // Digit 2 changes after it was sampled; the old glyph must stick.
    hv = '{7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40};
    applyStimulus(hv);
    startScan(hv);
    repeat (3) @(posedge clk);
    #1;
    bus.HEX2 = 7'h79;
    repeat (5) @(posedge clk);
    #1;
    checkOutput("lateChangeDigit2", 32'(bus.Value[11:8]), 32'd0);
    sb.delete();

    // Reset in the middle of a scan.
    hv = '{7'h79, 7'h79, 7'h79, 7'h79, 7'h79, 7'h79};
    applyStimulus(hv);
    prevDone = doneCount;
    startScan(hv);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    sb.delete();
    checkOutput("midRstValue", 32'(bus.Value), 32'd0);
    checkOutput("midRstValid", 32'(bus.Valid), 32'd0);
    checkOutput("midRstBusy", 32'(bus.Busy), 32'd0);
    checkOutput("midRstDone", 32'(bus.Done), 32'd0);
    repeat (8) @(posedge clk);
    #1;
    checkOutput("midRstNoDone", 32'(doneCount - prevDone), 32'd0);
    runScan(hv);

    // Reset and Start together: reset wins.
    rst = 1'b1;
    bus.Start = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    bus.Start = 1'b0;
    checkOutput("rstStartBusy", 32'(bus.Busy), 32'd0);
    @(posedge clk);
    #1;
    checkOutput("rstStartBusyLater", 32'(bus.Busy), 32'd0);

    // Random mix of legal, blank and arbitrary patterns.
    for (int n = 0; n < 25; n++) begin
      for (int d = 0; d < 6; d++) begin
        int sel;
        sel = $urandom_range(0, 9);
        if (sel < 5) hv[d] = glyphs[$urandom_range(0, 15)];
        else if (sel < 7) hv[d] = 7'h7F;
        else hv[d] = 7'($urandom_range(0, 127));
      end
      runScan(hv);
    end

    $display("%0d/%0d checks passed", passCount, totalCount);
    $finish;
  end

endmodule

// File: doc/hex_decode_scan.md
HEX_DECODE_SCAN -- requirements
Module: hex_decode_scan

Interface
REQ-001 SHALL have one clock and a synchronous, active-high reset; all state changes on the rising edge of CLOCK_50.
REQ-002 CLOCK_50  input  1  system clock.
REQ-003 Reset  input  1  synchronous active-high reset, sampled on the CLOCK_50 rising edge.
REQ-004 Start  input  1  single-cycle request to begin a scan of all six displays.
REQ-005 HEX0..HEX5  input  7 each  DE-series segment patterns, active-low, bit0=a through bit6=g.
REQ-006 Value  output  24  decoded nibbles; Value[4i+3:4i] holds the digit from HEXi.
REQ-007 Valid  output  6  Valid[i]=1 when HEXi held a legal hex glyph in the last scan.
REQ-008 Blank  output  6  Blank[i]=1 when HEXi was 7'h7F (all segments off) in the last scan.
REQ-009 ErrCnt  output  3  count of digits in the last scan that were neither legal nor blank (0..6).
REQ-010 Busy  output  1  high while a scan is in progress.
REQ-011 Done  output  1  one-cycle pulse when a scan completes.

Function
REQ-012 SHALL implement FSM states IDLE, SCAN and DONE, plus a 3-bit digit index Idx.
REQ-013 IDLE with Start=1 SHALL go to SCAN with Idx=0, clear ErrCnt, and keep Value, Valid and Blank unchanged until each digit is rewritten.
REQ-014 SCAN SHALL decode HEX[Idx] as sampled in that cycle, write Value/Valid/Blank for digit Idx, and increment Idx; after Idx=5 it SHALL go to DONE.
REQ-015 DONE SHALL assert Done for exactly one cycle and then return to IDLE.
REQ-016 Busy SHALL be 1 exactly in the SCAN state; for Start at edge t, Busy is high for cycles t+1..t+6 and Done is high in cycle t+7.
REQ-017 Start in SCAN or DONE SHALL be ignored; it is neither queued nor restarts the scan.
REQ-018 Legal glyphs (pattern->nibble): 40->0 79->1 24->2 30->3 19->4 12->5 02->6 78->7 00->8 10->9 08->A 03->b 46->C 21->d 06->E 0E->F (7-bit hex).
REQ-019 Legal glyph SHALL set Valid[i]=1 and Blank[i]=0, and write the nibble.
REQ-020 Pattern 7'h7F SHALL set Valid[i]=0 and Blank[i]=1, write nibble 0, and leave ErrCnt unchanged.
REQ-021 Any other pattern SHALL set Valid[i]=0 and Blank[i]=0, write nibble 0, and increment ErrCnt by 1; ErrCnt cannot exceed 6, so no saturation is needed.
REQ-022 Each digit SHALL be sampled only in its own SCAN cycle; changes to HEXi after that cycle SHALL NOT affect the current result.
REQ-023 Outputs SHALL hold their values in IDLE until the next scan rewrites them.

Reset
REQ-024 Reset=1 SHALL force IDLE, Idx=0, Value=0, Valid=0, Blank=0, ErrCnt=0, Busy=0 and Done=0 on the next edge, from any state, including mid-scan.
REQ-025 Reset and Start asserted in the same cycle: reset SHALL win and no scan SHALL start.
REQ-026 Start SHALL be accepted on the first edge after Reset deasserts.

Verification
REQ-027 HEX0..5 = 40,79,24,30,19,12 with Start pulsed -> Busy for 6 cycles, Done at t+7, Value=24'h543210, Valid=6'h3F, Blank=0, ErrCnt=0.
REQ-028 HEX0..5 = 08,03,46,21,06,0E -> Value=24'hFEDCBA, Valid=6'h3F, ErrCnt=0.
REQ-029 HEX0=7F, HEX1=55, HEX2=00, HEX3=7F, HEX4=01, HEX5=79 -> Valid=6'b100100, Blank=6'b001001, ErrCnt=2, Value=24'h100800.
REQ-030 Start asserted in cycles t, t+2 and t+7 -> exactly one scan runs and Done pulses only at t+7; a new scan starts only on a Start in IDLE at t+8 or later.
REQ-031 Reset asserted at t+3 of a scan -> next cycle all outputs are 0 and the state is IDLE; a following Start gives a full, correct scan.
REQ-032 HEX2 changed from 40 to 79 in cycle t+4 (after digit 2 was sampled at t+3) -> Value[11:8]=0 remains.
